// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: register-index width,
// the never-forwarded PC index and the operand forward-select encodings.
package hazard_unit_pkg;

  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] regIdx_t;

  localparam regIdx_t PC_REG = 4'd15;

  localparam logic [2:0] FWD_RF    = 3'b000;
  localparam logic [2:0] FWD_ALUM  = 3'b010;
  localparam logic [2:0] FWD_ALU2M = 3'b011;
  localparam logic [2:0] FWD_RESW  = 3'b001;
  localparam logic [2:0] FWD_RES2W = 3'b100;

  function automatic logic regMatch(input regIdx_t src, input regIdx_t dst, input logic wrEn);
    return wrEn && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Priority forward select for one E-stage source register: newest producer
// (M) beats older (W), primary destination beats the long-multiply high word.
module fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] raE,
  input  logic [REG_W-1:0] wa3M,
  input  logic [REG_W-1:0] wa4M,
  input  logic [REG_W-1:0] wa3W,
  input  logic [REG_W-1:0] wa4W,
  input  logic             regWriteM,
  input  logic             regWrite2M,
  input  logic             regWriteW,
  input  logic             regWrite2W,
  output logic [2:0]       fwd
);

  always_comb begin
    fwd = FWD_RF;
    // The PC is read through its own path, so it never takes a bypass.
    if (raE != PC_REG) begin
      if      (regMatch(raE, wa3M, regWriteM))  fwd = FWD_ALUM;
      else if (regMatch(raE, wa4M, regWrite2M)) fwd = FWD_ALU2M;
      else if (regMatch(raE, wa3W, regWriteW))  fwd = FWD_RESW;
      else if (regMatch(raE, wa4W, regWrite2W)) fwd = FWD_RES2W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage core: register-address
// pipeline, load-use/PC-write stalls and flushes, saturating event counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA3D,
  input  logic [REG_W-1:0] WA3D,
  input  logic [REG_W-1:0] WA4D,
  input  logic             MemToRegE,
  input  logic             BranchTakenE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             RegWrite2M,
  input  logic             RegWrite2W,
  output logic [2:0]       ForwardAE,
  output logic [2:0]       ForwardBE,
  output logic [2:0]       ForwardCE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int NUM_OPS = 3;

  logic [REG_W-1:0] RA1E, RA2E, RA3E, WA3E, WA4E;
  logic [REG_W-1:0] WA3M, WA4M, WA3W, WA4W;
  logic ldrStall, pcWrPending;

  logic [NUM_OPS-1:0][REG_W-1:0] raE;
  logic [NUM_OPS-1:0][2:0]       fwdE;

  // D->E: a flushed slot carries PC_REG so it can never match anything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RA1E <= PC_REG;
      RA2E <= PC_REG;
      RA3E <= PC_REG;
      WA3E <= PC_REG;
      WA4E <= PC_REG;
    end else if (FlushE) begin
      RA1E <= PC_REG;
      RA2E <= PC_REG;
      RA3E <= PC_REG;
      WA3E <= PC_REG;
      WA4E <= PC_REG;
    end else begin
      RA1E <= RA1D;
      RA2E <= RA2D;
      RA3E <= RA3D;
      WA3E <= WA3D;
      WA4E <= WA4D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WA3M <= PC_REG;
      WA4M <= PC_REG;
      WA3W <= PC_REG;
      WA4W <= PC_REG;
    end else begin
      WA3M <= WA3E;
      WA4M <= WA4E;
      WA3W <= WA3M;
      WA4W <= WA4M;
    end
  end

  assign raE = {RA3E, RA2E, RA1E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : gOp
    fwd_sel uFwd (
      .raE        (raE[i]),
      .wa3M       (WA3M),
      .wa4M       (WA4M),
      .wa3W       (WA3W),
      .wa4W       (WA4W),
      .regWriteM  (RegWriteM),
      .regWrite2M (RegWrite2M),
      .regWriteW  (RegWriteW),
      .regWrite2W (RegWrite2W),
      .fwd        (fwdE[i])
    );
  end

  assign ForwardAE = fwdE[0];
  assign ForwardBE = fwdE[1];
  assign ForwardCE = fwdE[2];

  assign ldrStall = MemToRegE && (WA3E != PC_REG) &&
                    ((RA1D == WA3E) || (RA2D == WA3E) || (RA3D == WA3E));
  assign pcWrPending = PCSrcD || PCSrcE || PCSrcM;

  // A taken branch alongside a load-use stall still flushes D, discarding
  // the instruction that the stall holds.
  assign StallF = ldrStall || pcWrPending;
  assign StallD = ldrStall;
  assign FlushD = pcWrPending || PCSrcW || BranchTakenE;
  assign FlushE = ldrStall || BranchTakenE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != '1)) StallCount <= StallCount + 1'b1;
      if (FlushE && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding priority, load-use, branch and
// PC-write flushes, counter saturation and asynchronous mid-run reset.
module tb_hazard_unit;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] RA1D, RA2D, RA3D, WA3D, WA4D;
  logic MemToRegE, BranchTakenE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic RegWriteM, RegWriteW, RegWrite2M, RegWrite2W;
  logic [2:0] ForwardAE, ForwardBE, ForwardCE;
  logic StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int nChecks = 0;
  int nErrors = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D), .WA3D(WA3D), .WA4D(WA4D),
    .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RegWrite2M(RegWrite2M), .RegWrite2W(RegWrite2W),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] w3, input logic [3:0] w4);
    RA1D = a; RA2D = b; RA3D = c; WA3D = w3; WA4D = w4;
  endtask

  task automatic ctlZero();
    MemToRegE = 0; BranchTakenE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    RegWriteM = 0; RegWriteW = 0; RegWrite2M = 0; RegWrite2W = 0;
  endtask

  initial begin
    ctlZero();
    setD(15, 15, 15, 15, 15);
    reset = 0;
    #1 reset = 1;

    // Reset state: forwards forced off even with write enables up.
    @(posedge clk); #1;
    RegWriteM = 1; RegWriteW = 1; RegWrite2M = 1; RegWrite2W = 1;
    #1;
    chk("rst_stallcnt", 64'(StallCount), 0);
    chk("rst_flushcnt", 64'(FlushCount), 0);
    chk("rst_fwd", 64'({ForwardAE, ForwardBE, ForwardCE}), 0);
    chk("rst_hazards", 64'({StallF, StallD, FlushD, FlushE}), 0);
    ctlZero();
    reset = 0;
    tick();

    // Forward from M beats W.
    setD(0, 0, 15, 1, 15);  tick();
    setD(15, 15, 15, 1, 15); tick();
    setD(1, 0, 15, 0, 15);  tick();
    RegWriteM = 1; RegWriteW = 1; #1;
    chk("fwdA_M_over_W", 64'(ForwardAE), 3'b010);
    chk("fwdB_none", 64'(ForwardBE), 3'b000);
    RegWrite2M = 1; #1;
    chk("fwdC_pcreg", 64'(ForwardCE), 3'b000);
    RegWriteM = 0; #1;
    chk("fwdA_W", 64'(ForwardAE), 3'b001);
    RegWriteW = 0; #1;
    chk("fwdA_off", 64'(ForwardAE), 3'b000);
    ctlZero();

    // Long multiply high word from M, then from W.
    setD(15, 15, 15, 4, 5);  tick();
    setD(15, 5, 15, 15, 15); tick();
    RegWriteM = 1; RegWrite2M = 1; #1;
    chk("fwdB_ALU2M", 64'(ForwardBE), 3'b011);
    chk("fwdA_pc_M", 64'(ForwardAE), 3'b000);
    setD(15, 5, 15, 15, 15); tick();
    RegWriteW = 1; RegWrite2W = 1; #1;
    chk("fwdB_RES2W", 64'(ForwardBE), 3'b100);
    chk("fwdA_pc_all", 64'(ForwardAE), 3'b000);
    ctlZero();

    // Load-use stall on operand C, then the flushed slot cannot match.
    setD(15, 15, 15, 2, 15); tick();
    MemToRegE = 1;
    setD(15, 15, 2, 15, 15); #1;
    chk("ldr_hazards", 64'({StallF, StallD, FlushD, FlushE}), 4'b1101);
    tick();
    setD(15, 15, 15, 15, 15); #1;
    chk("ldr_pc_nostall", 64'({StallF, StallD, FlushE}), 3'b000);
    chk("ldr_stallcnt", 64'(StallCount), 1);
    chk("ldr_flushcnt", 64'(FlushCount), 1);
    MemToRegE = 0;

    // Branch taken.
    BranchTakenE = 1; #1;
    chk("br_hazards", 64'({StallF, StallD, FlushD, FlushE}), 4'b0011);
    tick();
    BranchTakenE = 0; #1;
    chk("br_flushcnt", 64'(FlushCount), 2);
    chk("br_stallcnt", 64'(StallCount), 1);

    // PC write walks D, E, M, W.
    for (int i = 0; i < 4; i++) begin
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3);
      #1;
      chk($sformatf("pcw_%0d", i), 64'({StallF, StallD, FlushD, FlushE}),
          (i < 3) ? 64'b1010 : 64'b0010);
      tick();
    end
    ctlZero(); #1;
    chk("pcw_done", 64'({StallF, FlushD}), 2'b00);
    chk("pcw_flushcnt", 64'(FlushCount), 2);

    // Load-use and taken branch together.
    setD(15, 15, 15, 3, 15); tick();
    MemToRegE = 1; BranchTakenE = 1;
    setD(3, 15, 15, 15, 15); #1;
    chk("ldr_br_hazards", 64'({StallF, StallD, FlushD, FlushE}), 4'b1111);
    tick();
    ctlZero(); #1;
    chk("ldr_br_stallcnt", 64'(StallCount), 2);
    chk("ldr_br_flushcnt", 64'(FlushCount), 3);

    // Repeated load-use: every other cycle stalls, 20 stalls saturate at 15.
    MemToRegE = 1;
    setD(15, 15, 2, 2, 15);
    for (int i = 0; i < 40; i++) tick();
    chk("sat_stallcnt", 64'(StallCount), 15);
    chk("sat_flushcnt", 64'(FlushCount), 15);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_stallcnt_hold", 64'(StallCount), 15);
    chk("sat_flushcnt_hold", 64'(FlushCount), 15);

    // Asynchronous reset in mid-cycle.
    MemToRegE = 0;
    RegWriteM = 1; RegWriteW = 1; RegWrite2M = 1; RegWrite2W = 1;
    #2 reset = 1;
    #1;
    chk("mid_rst_stallcnt", 64'(StallCount), 0);
    chk("mid_rst_flushcnt", 64'(FlushCount), 0);
    chk("mid_rst_fwd", 64'({ForwardAE, ForwardBE, ForwardCE}), 0);
    chk("mid_rst_hazards", 64'({StallF, StallD, FlushD, FlushE}), 0);
    chk("mid_rst_addr",
        64'({dut.RA1E, dut.RA2E, dut.RA3E, dut.WA3E, dut.WA4E,
             dut.WA3M, dut.WA4M, dut.WA3W, dut.WA4W}),
        64'(36'hF_FFFF_FFFF));
    ctlZero();
    reset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
